// File: rtl/word_packer_4to1_if.sv
// Handshake bundle for word_packer_4to1.
//   in_data/in_valid/in_ready      : word-wide producer side
//   out_data/out_valid/out_ready   : line-wide consumer side (line = 4 * WORD_W)
//   word_cnt                       : lanes filled in the current partial line
//   flush                          : present only when PACKER_FLUSH_EN is defined
// Modports: slave = packer view, master = producer/consumer (environment) view.
interface word_packer_4to1_if #(
  parameter int unsigned WORD_W = 32
);
  logic [WORD_W-1:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic [4*WORD_W-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic [1:0]          word_cnt;
`ifdef PACKER_FLUSH_EN
  logic                flush;
`endif

  modport slave (
`ifdef PACKER_FLUSH_EN
    input  flush,
`endif
    input  in_data,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_valid,
    output word_cnt
  );

  modport master (
`ifdef PACKER_FLUSH_EN
    output flush,
`endif
    output in_data,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_valid,
    input  word_cnt
  );
endinterface

// File: rtl/word_packer_4to1.sv
// word_packer_4to1: packs a stream of WORD_W-bit words into 4*WORD_W-bit lines.
// Word k of a line lands in out_data[WORD_W*k +: WORD_W]. A one-line output buffer
// lets the next line fill while the previous one waits for the consumer.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : word_packer_4to1_if.slave (word input, line output, word_cnt, flush)
// Optional feature: define PACKER_FLUSH_EN to enable the flush input, which emits a
// partial line (unfilled lanes zero), deferring it while the output slot is busy.
module word_packer_4to1 #(
  parameter int unsigned WORD_W = 32
) (
  input logic               clk,
  input logic               rst,
  word_packer_4to1_if.slave bus
);

  logic [2:0][WORD_W-1:0] acc_q, acc_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [4*WORD_W-1:0]    out_q, out_d;
  logic                   ov_q, ov_d;
  logic                   slot_free;
  logic                   accept;
  logic                   in_ready;
`ifdef PACKER_FLUSH_EN
  logic                   pend_q, pend_d;
`endif

  assign slot_free = !ov_q || bus.out_ready;

`ifdef PACKER_FLUSH_EN
  assign in_ready = ((cnt_q != 2'd3) || slot_free) && !pend_q;
`else
  assign in_ready = (cnt_q != 2'd3) || slot_free;
`endif

  assign accept = bus.in_valid && in_ready;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    out_d = out_q;
    ov_d  = ov_q;
`ifdef PACKER_FLUSH_EN
    pend_d = pend_q;
`endif
    if (accept && (cnt_q == 2'd3)) begin
      // Full line; a simultaneous output transfer is covered since ov stays set.
      out_d = {bus.in_data, acc_q};
      ov_d  = 1'b1;
      cnt_d = 2'd0;
      acc_d = '0;
`ifdef PACKER_FLUSH_EN
      pend_d = 1'b0;
`endif
    end else begin
      if (accept) begin
        acc_d[cnt_q] = bus.in_data;
        cnt_d        = cnt_q + 2'd1;
      end
      if (ov_q && bus.out_ready) begin
        ov_d = 1'b0;
      end
`ifdef PACKER_FLUSH_EN
      // acc_d already holds the word accepted this cycle; lanes not yet written are
      // zero because the accumulator is cleared whenever a line leaves.
      if ((bus.flush || pend_q) && ((cnt_q != 2'd0) || accept)) begin
        if (slot_free) begin
          out_d  = {{WORD_W{1'b0}}, acc_d};
          ov_d   = 1'b1;
          cnt_d  = 2'd0;
          acc_d  = '0;
          pend_d = 1'b0;
        end else begin
          pend_d = 1'b1;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= 2'd0;
      out_q <= '0;
      ov_q  <= 1'b0;
`ifdef PACKER_FLUSH_EN
      pend_q <= 1'b0;
`endif
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      ov_q  <= ov_d;
`ifdef PACKER_FLUSH_EN
      pend_q <= pend_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_q;
  assign bus.out_valid = ov_q;
  assign bus.word_cnt  = cnt_q;

endmodule

// File: tb/tb_word_packer_4to1.sv
module tb_word_packer_4to1;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  word_packer_4to1_if #(.WORD_W(W)) bus ();

  word_packer_4to1 #(.WORD_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: the partial line is a queue of accepted words, the output
  // slot is a line value plus a valid flag.
  logic [W-1:0]   m_part[$];
  logic [4*W-1:0] m_out;
  logic           m_ov;
  logic           m_pend;
  logic           exp_in_ready;

  logic           obs_in_ready;
  logic           obs_ov;
  logic [4*W-1:0] obs_out;
  logic [1:0]     obs_cnt;

  function automatic logic [4*W-1:0] pack(input logic [W-1:0] q[$]);
    logic [4*W-1:0] l;
    l = '0;
    for (int i = 0; i < q.size(); i++) l[i*W +: W] = q[i];
    return l;
  endfunction

  task automatic model_reset();
    m_part.delete();
    m_out  = '0;
    m_ov   = 1'b0;
    m_pend = 1'b0;
  endtask

  // Drive one cycle (inputs already past negedge), capture in_ready, clock,
  // update the model and capture registered outputs at the following negedge.
  task automatic drive_cycle(input logic v, input logic [W-1:0] d, input logic ordy,
                             input logic fl);
    logic acc, sf, fl_eff;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
`ifdef PACKER_FLUSH_EN
    bus.flush = fl;
    fl_eff    = fl;
`else
    fl_eff    = 1'b0 & fl;
`endif
    #1;
    obs_in_ready = bus.in_ready;
    sf           = !m_ov || ordy;
    exp_in_ready = (m_part.size() < 3 || sf) && !m_pend;
    acc          = v && exp_in_ready;
    @(posedge clk);
    if (acc) m_part.push_back(d);
    if (m_part.size() == 4) begin
      m_out  = pack(m_part);
      m_ov   = 1'b1;
      m_part.delete();
      m_pend = 1'b0;
    end else begin
      if (m_ov && ordy) m_ov = 1'b0;
      if ((fl_eff || m_pend) && m_part.size() > 0) begin
        if (sf) begin
          m_out  = pack(m_part);
          m_ov   = 1'b1;
          m_part.delete();
          m_pend = 1'b0;
        end else begin
          m_pend = 1'b1;
        end
      end
    end
    @(negedge clk);
    obs_ov  = bus.out_valid;
    obs_out = bus.out_data;
    obs_cnt = bus.word_cnt;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef PACKER_FLUSH_EN
    bus.flush = 1'b0;
`endif
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.word_cnt !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: got ov=%b out=%h cnt=%0d expected 0/0/0",
               bus.out_valid, bus.out_data, bus.word_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single_line();
    logic [W-1:0] w[4] = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_cnt !== 2'(i)) begin
        failures++;
        $display("FAIL single_cnt%0d: got %0d expected %0d", i, obs_cnt, i);
      end
      drive_cycle(1'b1, w[i], 1'b1, 1'b0);
    end
    checks++;
    if (obs_ov !== 1'b1 || obs_out !== {w[3], w[2], w[1], w[0]} || obs_cnt !== 2'd0) begin
      failures++;
      $display("FAIL single_line: got ov=%b out=%h cnt=%0d expected 1/%h/0",
               obs_ov, obs_out, obs_cnt, {w[3], w[2], w[1], w[0]});
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (obs_ov !== 1'b0 || obs_out !== {w[3], w[2], w[1], w[0]}) begin
      failures++;
      $display("FAIL single_drain: got ov=%b out=%h expected 0 with held line", obs_ov,
               obs_out);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, $urandom, 1'b1, 1'b0);
      checks++;
      if (obs_in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready%0d: got %b expected 1", i, obs_in_ready);
      end
      checks++;
      if (obs_ov !== ((i % 4) == 3) || obs_out !== m_out) begin
        failures++;
        $display("FAIL b2b_out%0d: got ov=%b out=%h expected %b/%h", i, obs_ov, obs_out,
                 ((i % 4) == 3), m_out);
      end
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [4*W-1:0] line1;
    logic [W-1:0]   last;
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, $urandom, 1'b0, 1'b0);
    line1 = m_out;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, $urandom, 1'b0, 1'b0);
    last = $urandom;
    drive_cycle(1'b1, last, 1'b0, 1'b0);
    checks++;
    if (obs_in_ready !== 1'b0 || obs_cnt !== 2'd3 || obs_out !== line1 || obs_ov !== 1'b1)
    begin
      failures++;
      $display("FAIL bp_stall: got rdy=%b cnt=%0d ov=%b out=%h expected 0/3/1/%h",
               obs_in_ready, obs_cnt, obs_ov, obs_out, line1);
    end
    drive_cycle(1'b1, last, 1'b1, 1'b0);
    checks++;
    if (obs_in_ready !== 1'b1 || obs_ov !== 1'b1 || obs_out !== m_out ||
        obs_out[3*W +: W] !== last || obs_cnt !== 2'd0) begin
      failures++;
      $display("FAIL bp_release: got rdy=%b ov=%b out=%h cnt=%0d expected 1/1/%h/0",
               obs_in_ready, obs_ov, obs_out, obs_cnt, m_out);
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, $urandom, 1'b0, 1'b0);
    checks++;
    if (obs_ov !== 1'b1 || obs_cnt !== 2'd2) begin
      failures++;
      $display("FAIL arst_setup: got ov=%b cnt=%0d expected 1/2", obs_ov, obs_cnt);
    end
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.word_cnt !== 2'd0) begin
      failures++;
      $display("FAIL arst_immediate: got ov=%b out=%h cnt=%0d expected 0/0/0",
               bus.out_valid, bus.out_data, bus.word_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 32'hC0DE_0000 + 32'(i), 1'b1, 1'b0);
    checks++;
    if (obs_ov !== 1'b1 || obs_out !== 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000) begin
      failures++;
      $display("FAIL arst_clean_line: got ov=%b out=%h expected 1/%h", obs_ov, obs_out,
               128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000);
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

`ifdef PACKER_FLUSH_EN
  task automatic test_flush();
    drive_cycle(1'b1, 32'h11, 1'b1, 1'b0);
    drive_cycle(1'b1, 32'h22, 1'b1, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (obs_ov !== 1'b1 || obs_out !== 128'h00000000_00000000_00000022_00000011 ||
        obs_cnt !== 2'd0) begin
      failures++;
      $display("FAIL flush_free: got ov=%b out=%h cnt=%0d expected 1/%h/0", obs_ov,
               obs_out, obs_cnt, 128'h00000000_00000000_00000022_00000011);
    end
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (obs_ov !== 1'b1 || obs_cnt !== 2'd0) begin
      failures++;
      $display("FAIL flush_empty_noop: got ov=%b cnt=%0d expected 1/0", obs_ov, obs_cnt);
    end
  endtask

  task automatic test_flush_pending();
    drive_cycle(1'b1, 32'h33, 1'b0, 1'b1);
    drive_cycle(1'b1, 32'h44, 1'b0, 1'b0);
    checks++;
    if (obs_in_ready !== 1'b0 || obs_cnt !== 2'd1 || obs_ov !== 1'b1) begin
      failures++;
      $display("FAIL flush_pending: got rdy=%b cnt=%0d ov=%b expected 0/1/1",
               obs_in_ready, obs_cnt, obs_ov);
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (obs_ov !== 1'b1 || obs_out !== 128'h33 || obs_cnt !== 2'd0) begin
      failures++;
      $display("FAIL flush_deferred: got ov=%b out=%h cnt=%0d expected 1/%h/0", obs_ov,
               obs_out, obs_cnt, 128'h33);
    end
    drive_cycle(1'b1, 32'h55, 1'b1, 1'b0);
    checks++;
    if (obs_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_resume: got rdy=%b expected 1", obs_in_ready);
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b1);
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      drive_cycle(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 9) == 0));
      checks++;
      if (obs_in_ready !== exp_in_ready) begin
        failures++;
        $display("FAIL rand_ready@%0d: got %b expected %b", i, obs_in_ready, exp_in_ready);
      end
      checks++;
      if (obs_ov !== m_ov || obs_out !== m_out || obs_cnt !== 2'(m_part.size())) begin
        failures++;
        $display("FAIL rand_out@%0d: got ov=%b out=%h cnt=%0d expected %b/%h/%0d", i,
                 obs_ov, obs_out, obs_cnt, m_ov, m_out, m_part.size());
      end
    end
  endtask

  initial begin
    idle_inputs();
    obs_cnt = 2'd0;
    @(negedge clk);
    test_reset();
    test_single_line();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
`ifdef PACKER_FLUSH_EN
    test_flush();
    test_flush_pending();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
